wiredng_mshr_file: RTL
======================

// Module: wiredng_mshr_file
// PURPOSE
//  Parametrised MSHR array, successor of the single-manager refill path. Tracks up to MSHR_COUNT
//  outstanding line refills and merges same-line requests. Issues TL-C AcquireBlock (A), streams
//  GrantData beats (D) to the cache data path, returns GrantAck (E), retires the entry.
//  Sits between the CPU refill-request side and the TileLink host port.
// PARAMETERS
//  MSHR_COUNT=8      outstanding entries (power of 2, >=2)
//  PA_LENGTH=48      physical address width
//  LINE_BYTES=128    cache line size; BEATS=LINE_BYTES/16 (128-bit D data)
//  SOURCE_WIDTH=3    TL source width, >= $clog2(MSHR_COUNT)
//  SINK_WIDTH=1      TL sink width
//  SOURCE_BASE=0     A source = SOURCE_BASE+entry index
// PORTS
//  clk            in  1          clock
//  rst_n          in  1          async active-low reset
//  req_valid_i    in  1          refill request
//  req_ready_o    out 1          accepted this cycle when valid&ready
//  req_paddr_i    in  PA_LENGTH  request address; line tag = paddr[PA-1:log2(LINE_BYTES)]
//  req_write_i    in  1          needs Trunk ownership (NtoT), else NtoB
//  req_id_o       out log2(MSHR) entry index (allocated or merged), valid on handshake
//  req_merge_o    out 1          request merged into a live entry
//  tl_a_valid_o/tl_a_ready_i 1; tl_a_opcode_o 3 (=6); tl_a_param_o 3 (NtoB=0/NtoT=1);
//  tl_a_size_o 4 (=log2 LINE_BYTES); tl_a_source_o SOURCE_WIDTH; tl_a_address_o PA_LENGTH (line-aligned)
//  tl_d_valid_i in 1; tl_d_ready_o out 1; tl_d_opcode_i 3; tl_d_source_i SOURCE_WIDTH;
//  tl_d_sink_i SINK_WIDTH; tl_d_data_i 128; tl_d_denied_i 1; tl_d_corrupt_i 1
//  tl_e_valid_o out 1; tl_e_ready_i in 1; tl_e_sink_o out SINK_WIDTH   GrantAck
//  beat_valid_o/beat_ready_i 1; beat_id_o log2(MSHR); beat_idx_o log2(BEATS); beat_data_o 128; beat_last_o 1
//  done_valid_o   out 1          1-cycle retire pulse; done_id_o log2(MSHR); done_err_o 1
//  req_clean_i    in  1          block new requests; clean_o out 1 = all entries IDLE
// BEHAVIOUR
//  Reset: all entries IDLE, beat counter 0, RR pointers 0; all valid outputs 0, clean_o=1.
//  Entry FSM: IDLE -alloc-> ACQ -A fire-> DATA -last D beat-> ACK -E fire-> IDLE (+done pulse).
//  Request path (comb.): compare line tag vs all non-IDLE entries.
//   - hit & (!req_write_i | entry param NtoT): ready=1, merge=1, id=hit index, no alloc.
//   - hit & req_write_i & entry NtoB: ready=0 (stall until that entry retires).
//   - miss: ready = any IDLE; allocate lowest IDLE index, merge=0.
//   - req_clean_i=1: ready=0 regardless.
//  Entry freed this cycle is allocatable next cycle, not same cycle; tag compare excludes it.
//  A: round-robin among ACQ entries; holds valid/payload stable until ready. mask all-ones.
//  D: TL forbids beat interleaving, so one shared beat counter. tl_d_ready_o = beat_ready_i.
//   Beat out comb.: beat_valid_o=tl_d_valid_i, id=d_source-SOURCE_BASE, idx=counter.
//   On fire: counter++, wraps to 0 after BEATS-1; beat_last_o when counter==BEATS-1.
//   Last beat: latch d_sink into entry, entry->ACK. denied|corrupt on any beat sets sticky err.
//   D opcode!=GrantData(5), or source maps to non-DATA entry: drop beat (ready=1); sim assertion.
//  E: round-robin among ACK entries; on fire entry->IDLE, done_valid_o=1 next cycle, done_err_o=err.
//  Simultaneous: A fire, D last beat and E fire on different entries in one cycle all commit.
//  clean_o = no entry non-IDLE (registered OR of states); in-flight entries still complete.
//  Reset mid-transfer: all state dropped; upstream handshakes restart from scratch.
// STRUCTURE
//  Package wiredng_mshr_pkg: mshr_state_e {IDLE,ACQ,DATA,ACK}, mshr_t {state,line_tag,
//  param,sink,err}, TL_ACQUIRE_BLOCK=6, TL_GRANT_DATA=5, TL_NTOB=0, TL_NTOT=1.
//  Sub-module: wiredng_rr_arbiter #(N) (req vector, grant one-hot, advance on fire), used for A and E.
// TESTING
//  Single read 0x1000 -> A src=0 param=0 addr=0x1000 size=7; 8 D beats idx 0..7, last on 7; E sink; done id 0 err 0.
//  8 misses to distinct lines -> ids 0..7, 9th miss ready=0; after id 3 retires, next miss gets id 3.
//  Read 0x2000 then read 0x2040 -> merge=1 id same, one A only; write 0x2000 vs NtoB entry -> stalls until done.
//  beat_ready_i toggled 1/0 every cycle -> tl_d_ready_o mirrors it; beat idx no skip/dup; data matches D.
//  D beat 4 corrupt=1 -> done_err_o=1 for that id; E still sent.
//  req_clean_i=1 with 2 live entries -> ready=0, clean_o=0 until both retire, then clean_o=1.

Source files
------------

// File: rtl/wiredng_mshr_pkg.sv
// Shared types and TileLink constants for the MSHR file.
// Entry fields are sized for the widest supported tag and sink; the top zero-extends into them.
package wiredng_mshr_pkg;

  localparam int MSHR_TAG_W  = 64;
  localparam int MSHR_SINK_W = 8;

  localparam logic [2:0] TL_ACQUIRE_BLOCK = 3'd6;
  localparam logic [2:0] TL_GRANT_DATA    = 3'd5;
  localparam logic [2:0] TL_NTOB          = 3'd0;
  localparam logic [2:0] TL_NTOT          = 3'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    DATA = 2'd2,
    ACK  = 2'd3
  } mshr_state_e;

  typedef struct packed {
    mshr_state_e             state;
    logic [MSHR_TAG_W-1:0]   line_tag;
    logic [2:0]              param;
    logic [MSHR_SINK_W-1:0]  sink;
    logic                    err;
  } mshr_t;

endpackage

// File: rtl/wiredng_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after the pointer and
// holds that choice until it fires, so a granted channel payload never changes mid-handshake.
module wiredng_rr_arbiter #(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req_i,
  input  logic                 fire_i,
  output logic                 valid_o,
  output logic [N-1:0]         grant_o,
  output logic [$clog2(N)-1:0] grant_idx_o
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr_q;
  logic          hold_q;
  logic [IW-1:0] hold_idx_q;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] cand;
  logic          found;

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    pick_idx = '0;
    cand     = '0;
    found    = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand = ptr_q + IW'(k);
      if (!found && req_i[cand]) begin
        found    = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign valid_o     = |req_i;
  assign grant_idx_o = hold_q ? hold_idx_q : pick_idx;
  assign grant_o     = valid_o ? (N'(1) << grant_idx_o) : '0;

  // NOTE: registered state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      hold_q     <= 1'b0;
      hold_idx_q <= '0;
    end else if (fire_i) begin
      ptr_q  <= grant_idx_o + IW'(1);
      hold_q <= 1'b0;
    end else if (valid_o) begin
      hold_q     <= 1'b1;
      hold_idx_q <= grant_idx_o;
    end
  end

endmodule

// File: rtl/wiredng_mshr_file.sv
// MSHR array: allocates or merges refill requests, issues AcquireBlock, streams
// GrantData beats to the data path, returns GrantAck and retires the entry.
module wiredng_mshr_file
  import wiredng_mshr_pkg::*;
#(
  parameter int MSHR_COUNT   = 8,
  parameter int PA_LENGTH    = 48,
  parameter int LINE_BYTES   = 128,
  parameter int SOURCE_WIDTH = 3,
  parameter int SINK_WIDTH   = 1,
  parameter int SOURCE_BASE  = 0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               req_valid_i,
  output logic                               req_ready_o,
  input  logic [PA_LENGTH-1:0]               req_paddr_i,
  input  logic                               req_write_i,
  output logic [$clog2(MSHR_COUNT)-1:0]      req_id_o,
  output logic                               req_merge_o,
  output logic                               tl_a_valid_o,
  input  logic                               tl_a_ready_i,
  output logic [2:0]                         tl_a_opcode_o,
  output logic [2:0]                         tl_a_param_o,
  output logic [3:0]                         tl_a_size_o,
  output logic [SOURCE_WIDTH-1:0]            tl_a_source_o,
  output logic [PA_LENGTH-1:0]               tl_a_address_o,
  output logic [15:0]                        tl_a_mask_o,
  input  logic                               tl_d_valid_i,
  output logic                               tl_d_ready_o,
  input  logic [2:0]                         tl_d_opcode_i,
  input  logic [SOURCE_WIDTH-1:0]            tl_d_source_i,
  input  logic [SINK_WIDTH-1:0]              tl_d_sink_i,
  input  logic [127:0]                       tl_d_data_i,
  input  logic                               tl_d_denied_i,
  input  logic                               tl_d_corrupt_i,
  output logic                               tl_e_valid_o,
  input  logic                               tl_e_ready_i,
  output logic [SINK_WIDTH-1:0]              tl_e_sink_o,
  output logic                               beat_valid_o,
  input  logic                               beat_ready_i,
  output logic [$clog2(MSHR_COUNT)-1:0]      beat_id_o,
  output logic [$clog2(LINE_BYTES/16)-1:0]   beat_idx_o,
  output logic [127:0]                       beat_data_o,
  output logic                               beat_last_o,
  output logic                               done_valid_o,
  output logic [$clog2(MSHR_COUNT)-1:0]      done_id_o,
  output logic                               done_err_o,
  input  logic                               req_clean_i,
  output logic                               clean_o
);

  localparam int ID_W   = $clog2(MSHR_COUNT);
  localparam int BEATS  = LINE_BYTES / 16;
  localparam int BEAT_W = $clog2(BEATS);
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int TAG_W  = PA_LENGTH - OFF_W;
  localparam logic [SOURCE_WIDTH:0] SRC_BASE = (SOURCE_WIDTH+1)'(SOURCE_BASE);
  localparam logic [SOURCE_WIDTH:0] SRC_SPAN = (SOURCE_WIDTH+1)'(MSHR_COUNT);

  mshr_t             ent_q [MSHR_COUNT];
  mshr_t             ent_d [MSHR_COUNT];
  logic [BEAT_W-1:0] beat_cnt_q;
  logic              done_valid_q;
  logic [ID_W-1:0]   done_id_q;
  logic              done_err_q;
  logic              clean_q;
  logic              clean_d;

  logic [MSHR_COUNT-1:0] idle_vec, acq_vec, ack_vec, hit_vec, a_grant, e_grant;
  logic [ID_W-1:0]       hit_idx, alloc_idx, a_idx, e_idx, d_id;
  logic [MSHR_TAG_W-1:0] req_tag;
  logic                  hit, merge_ok, req_fire, alloc_fire;
  logic                  a_fire, e_fire, d_good, d_fire, d_err, beat_last;
  logic [SOURCE_WIDTH:0] src_ext, src_off;
  logic                  src_ok;
  logic [MSHR_SINK_W-1:0] e_sink_full;
  logic                  unused_bits;

  assign req_tag = MSHR_TAG_W'(req_paddr_i[PA_LENGTH-1:OFF_W]);

  always_comb begin
    idle_vec = '0;
    acq_vec  = '0;
    ack_vec  = '0;
    for (int i = 0; i < MSHR_COUNT; i++) begin
      idle_vec[i] = (ent_q[i].state == IDLE);
      acq_vec[i]  = (ent_q[i].state == ACQ);
      ack_vec[i]  = (ent_q[i].state == ACK);
    end
  end

  // An entry retiring this cycle no longer matches, yet is not allocatable until next cycle.
  always_comb begin
    hit_vec   = '0;
    hit_idx   = '0;
    alloc_idx = '0;
    for (int i = MSHR_COUNT - 1; i >= 0; i--) begin
      hit_vec[i] = !idle_vec[i] && !(e_fire && e_grant[i]) && (ent_q[i].line_tag == req_tag);
      if (hit_vec[i])  hit_idx   = ID_W'(i);
      if (idle_vec[i]) alloc_idx = ID_W'(i);
    end
  end

  assign hit         = |hit_vec;
  assign merge_ok    = !req_write_i || (ent_q[hit_idx].param == TL_NTOT);
  assign req_ready_o = !req_clean_i && (hit ? merge_ok : |idle_vec);
  assign req_merge_o = hit && merge_ok;
  assign req_id_o    = hit ? hit_idx : alloc_idx;
  assign req_fire    = req_valid_i && req_ready_o;
  assign alloc_fire  = req_fire && !hit;

  wiredng_rr_arbiter #(.N(MSHR_COUNT)) u_a_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (acq_vec),
    .fire_i      (a_fire),
    .valid_o     (tl_a_valid_o),
    .grant_o     (a_grant),
    .grant_idx_o (a_idx)
  );

  assign a_fire         = tl_a_valid_o && tl_a_ready_i;
  assign tl_a_opcode_o  = TL_ACQUIRE_BLOCK;
  assign tl_a_param_o   = ent_q[a_idx].param;
  assign tl_a_size_o    = 4'(OFF_W);
  assign tl_a_source_o  = SOURCE_WIDTH'(SOURCE_BASE) + SOURCE_WIDTH'(a_idx);
  assign tl_a_address_o = {ent_q[a_idx].line_tag[TAG_W-1:0], {OFF_W{1'b0}}};
  assign tl_a_mask_o    = '1;

  // D beats never interleave, so a single counter tracks the beat index of the current grant.
  assign src_ext   = {1'b0, tl_d_source_i};
  assign src_off   = src_ext - SRC_BASE;
  assign src_ok    = (src_ext >= SRC_BASE) && (src_off < SRC_SPAN);
  assign d_id      = src_off[ID_W-1:0];
  assign d_good    = (tl_d_opcode_i == TL_GRANT_DATA) && src_ok && (ent_q[d_id].state == DATA);
  assign d_fire    = tl_d_valid_i && d_good && beat_ready_i;
  assign d_err     = tl_d_denied_i || tl_d_corrupt_i;
  assign beat_last = (beat_cnt_q == BEAT_W'(BEATS - 1));

  assign tl_d_ready_o = beat_ready_i || (tl_d_valid_i && !d_good);
  assign beat_valid_o = tl_d_valid_i && d_good;
  assign beat_id_o    = d_id;
  assign beat_idx_o   = beat_cnt_q;
  assign beat_data_o  = tl_d_data_i;
  assign beat_last_o  = beat_last;

  wiredng_rr_arbiter #(.N(MSHR_COUNT)) u_e_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (ack_vec),
    .fire_i      (e_fire),
    .valid_o     (tl_e_valid_o),
    .grant_o     (e_grant),
    .grant_idx_o (e_idx)
  );

  assign e_fire      = tl_e_valid_o && tl_e_ready_i;
  assign e_sink_full = ent_q[e_idx].sink;
  assign tl_e_sink_o = e_sink_full[SINK_WIDTH-1:0];
  assign unused_bits = ^{req_paddr_i[OFF_W-1:0], e_sink_full[MSHR_SINK_W-1:SINK_WIDTH]};

  // Alloc, A, D and E each touch an entry in a different state, so all can commit together.
  always_comb begin
    ent_d = ent_q;
    for (int i = 0; i < MSHR_COUNT; i++) begin
      if (alloc_fire && (alloc_idx == ID_W'(i))) begin
        ent_d[i] = '{state: ACQ, line_tag: req_tag,
                     param: (req_write_i ? TL_NTOT : TL_NTOB),
                     sink: '0, err: 1'b0};
      end
      if (a_fire && a_grant[i]) ent_d[i].state = DATA;
      if (d_fire && (d_id == ID_W'(i))) begin
        if (d_err) ent_d[i].err = 1'b1;
        if (beat_last) begin
          ent_d[i].state = ACK;
          ent_d[i].sink  = MSHR_SINK_W'(tl_d_sink_i);
        end
      end
      if (e_fire && e_grant[i]) ent_d[i].state = IDLE;
    end
  end

  always_comb begin
    clean_d = 1'b1;
    for (int i = 0; i < MSHR_COUNT; i++) begin
      if (ent_d[i].state != IDLE) clean_d = 1'b0;
    end
  end

  // NOTE: the entry array is reset explicitly because its state field drives control; a pure data RAM would not be.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MSHR_COUNT; i++) ent_q[i] <= '0;
      beat_cnt_q   <= '0;
      done_valid_q <= 1'b0;
      done_id_q    <= '0;
      done_err_q   <= 1'b0;
      clean_q      <= 1'b1;
    end else begin
      ent_q        <= ent_d;
      clean_q      <= clean_d;
      done_valid_q <= e_fire;
      if (e_fire) begin
        done_id_q  <= e_idx;
        done_err_q <= ent_q[e_idx].err;
      end
      if (d_fire) beat_cnt_q <= beat_last ? '0 : beat_cnt_q + BEAT_W'(1);
    end
  end

  assign done_valid_o = done_valid_q;
  assign done_id_o    = done_id_q;
  assign done_err_o   = done_err_q;
  assign clean_o      = clean_q;

  a_d_beat_legal: assert property (@(posedge clk) disable iff (!rst_n) tl_d_valid_i |-> d_good)
    else $error("dropped D beat: unexpected opcode or source not in DATA state");

endmodule
